// File: rtl/timer_disp_pkg.sv
// Shared types, widths and segment encoding for the timer display driver.
package timer_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BIN_W      = 8;
  localparam int unsigned BCD_W      = 12;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-decimal codes blank.
  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] nibble);
    logic [SEG_W-1:0] seg;
    case (nibble)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/timer_display_driver_if.sv
// Timer-core-to-display bundle: binary count in, display pins and status out.
interface timer_display_driver_if;
  import timer_disp_pkg::*;

  logic [BIN_W-1:0]      msb_bin;
  logic [BIN_W-1:0]      lsb_bin;
  logic                  disp_en;
  logic [SEG_W-1:0]      seg_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic                  dp_n;
  logic                  busy;
  logic                  ovr;

  modport master (
    output msb_bin, lsb_bin, disp_en,
    input  seg_n, an_n, dp_n, busy, ovr
  );

  modport slave (
    input  msb_bin, lsb_bin, disp_en,
    output seg_n, an_n, dp_n, busy, ovr
  );

endinterface

// File: rtl/timer_display_driver_bin8_to_bcd.sv
// One 8-bit sequential double-dabble slice: load, then correct-and-shift per strobe.
module bin8_to_bcd
  import timer_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [BIN_W-1:0] i_bin,
  output logic [3:0]       o_hund,
  output logic [3:0]       o_tens,
  output logic [3:0]       o_ones
);

  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] w_adj;

  // +3 on every nibble >= 5 before the shift
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
    end else if (i_load) begin
      r_bin <= i_bin;
      r_bcd <= '0;
    end else if (i_shift) begin
      {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
    end
  end

  assign o_hund = r_bcd[11:8];
  assign o_tens = r_bcd[7:4];
  assign o_ones = r_bcd[3:0];

endmodule

// File: rtl/timer_display_driver.sv
// Binary MSB/LSB timer count to four-digit multiplexed seven-segment display.
// Optional build macro TIMER_DISP_LZ_BLANK_EN blanks a leading zero on digit 3.
module timer_display_driver
  import timer_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic                  clk,
  input logic                  rst_n,
  timer_display_driver_if.slave bus
);

  localparam int unsigned PRESC_W = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DIG_W   = 2;

  localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] S_SHIFT  = 2'(ST_SHIFT);
  localparam logic [1:0] S_COMMIT = 2'(ST_COMMIT);

  logic [1:0]            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  w_latch, w_load, w_shift, w_commit;
  logic                  r_busy;
  logic [BIN_W-1:0]      r_last_msb, r_last_lsb;
  logic [3:0]            w_msb_hund, w_msb_tens, w_msb_ones;
  logic [3:0]            w_lsb_hund, w_lsb_tens, w_lsb_ones;
  logic [3:0]            r_msb_tens, r_msb_ones, r_lsb_tens, r_lsb_ones;
  logic                  r_msb_hnz, r_lsb_hnz, r_ovr;
  logic [PRESC_W-1:0]    r_presc;
  logic [DIG_W-1:0]      r_digit;
  logic [SEG_W-1:0]      r_seg, w_seg;
  logic [NUM_DIGITS-1:0] r_an, w_an;
  logic                  r_dp, w_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // First SHIFT cycle loads the slices from the latched pair, the next eight shift
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ({bus.msb_bin, bus.lsb_bin} != {r_last_msb, r_last_lsb}) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_W'(0)) w_load = 1'b1;
        else                    w_shift = 1'b1;
        if (r_cnt == CNT_W'(8)) w_state_nxt = S_COMMIT;
        else                    w_cnt_nxt = r_cnt + CNT_W'(1);
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  bin8_to_bcd u_msb_bcd (
    .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_shift(w_shift), .i_bin(r_last_msb),
    .o_hund(w_msb_hund), .o_tens(w_msb_tens), .o_ones(w_msb_ones)
  );

  bin8_to_bcd u_lsb_bcd (
    .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_shift(w_shift), .i_bin(r_last_lsb),
    .o_hund(w_lsb_hund), .o_tens(w_lsb_tens), .o_ones(w_lsb_ones)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_msb <= '0;
      r_last_lsb <= '0;
      r_msb_tens <= '0;
      r_msb_ones <= '0;
      r_lsb_tens <= '0;
      r_lsb_ones <= '0;
      r_msb_hnz  <= 1'b0;
      r_lsb_hnz  <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (w_latch) begin
        r_last_msb <= bus.msb_bin;
        r_last_lsb <= bus.lsb_bin;
      end
      if (w_commit) begin
        r_msb_tens <= w_msb_tens;
        r_msb_ones <= w_msb_ones;
        r_lsb_tens <= w_lsb_tens;
        r_lsb_ones <= w_lsb_ones;
        r_msb_hnz  <= (w_msb_hund != 4'd0);
        r_lsb_hnz  <= (w_lsb_hund != 4'd0);
        r_ovr      <= (w_msb_hund != 4'd0) || (w_lsb_hund != 4'd0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_digit <= '0;
    end else if (r_presc == PRESC_W'(SCAN_DIV - 1)) begin
      r_presc <= '0;
      r_digit <= r_digit + DIG_W'(1);
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  // Digit mux: out-of-range fields show dashes on both their digits
  always_comb begin
    w_seg = SEG_BLANK;
    case (r_digit)
      2'd0: w_seg = r_lsb_hnz ? SEG_DASH : bcd_to_seg(r_lsb_ones);
      2'd1: w_seg = r_lsb_hnz ? SEG_DASH : bcd_to_seg(r_lsb_tens);
      2'd2: w_seg = r_msb_hnz ? SEG_DASH : bcd_to_seg(r_msb_ones);
      2'd3: w_seg = r_msb_hnz ? SEG_DASH : bcd_to_seg(r_msb_tens);
      default: w_seg = SEG_BLANK;
    endcase
    w_an = bus.disp_en ? ~(NUM_DIGITS'(1) << r_digit) : '1;
`ifdef TIMER_DISP_LZ_BLANK_EN
    if ((r_msb_tens == 4'd0) && !r_msb_hnz) w_an[3] = 1'b1;
`endif
    w_dp = !(bus.disp_en && (r_digit == DIG_W'(2)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
      r_dp  <= 1'b1;
    end else begin
      r_seg <= w_seg;
      r_an  <= w_an;
      r_dp  <= w_dp;
    end
  end

  assign bus.seg_n = r_seg;
  assign bus.an_n  = r_an;
  assign bus.dp_n  = r_dp;
  assign bus.busy  = r_busy;
  assign bus.ovr   = r_ovr;

endmodule

// File: tb/tb_timer_display_driver.sv
// Self-checking bench for timer_display_driver against a decimal/segment reference model.
module tb_timer_display_driver;

  localparam int unsigned SCAN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  timer_display_driver_if bus();

  timer_display_driver #(.SCAN_DIV(SCAN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [6:0] obs_seg [4];
  bit         seen [4];
  int         dp_err;
  int         an3_low;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected pattern of one digit of a field: pos 0 = ones, 1 = tens
  function automatic logic [6:0] exp_digit(input int value, input int pos);
    if (value > 99) return 7'b0111111;
    return seg_of(pos != 0 ? (value / 10) % 10 : value % 10);
  endfunction

  function automatic bit exp_seen(input int d, input int msb);
`ifdef TIMER_DISP_LZ_BLANK_EN
    if (d == 3) return (msb > 99) || (msb / 10 != 0);
`endif
    return (d >= 0) || (msb < 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int m, input int l);
    bus.msb_bin = 8'(m);
    bus.lsb_bin = 8'(l);
  endtask

  // Counts cycles with busy high after the current edge; bounded at 40
  task automatic busy_len(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.busy) n++;
      else break;
    end
  endtask

  task automatic capture(input int ncyc);
    int d;
    dp_err  = 0;
    an3_low = 0;
    for (int i = 0; i < 4; i++) seen[i] = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      tick();
      case (bus.an_n)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        default: d = -1;
      endcase
      if (d >= 0) begin
        seen[d]    = 1'b1;
        obs_seg[d] = bus.seg_n;
        if ((bus.dp_n == 1'b0) != (d == 2)) dp_err++;
      end else if (bus.dp_n == 1'b0 || bus.an_n != 4'b1111) begin
        dp_err++;
      end
      if (!bus.an_n[3]) an3_low++;
    end
  endtask

  task automatic test_reset();
    apply(0, 0);
    bus.disp_en = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    n_total++; if (bus.seg_n !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", bus.seg_n); else n_pass++;
    n_total++; if (bus.an_n !== 4'hF) $display("FAIL reset_an: got %h want f", bus.an_n); else n_pass++;
    n_total++; if (bus.dp_n !== 1'b1) $display("FAIL reset_dp: got %b want 1", bus.dp_n); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.ovr !== 1'b0) $display("FAIL reset_ovr: got %b want 0", bus.ovr); else n_pass++;
    rst_n = 1'b1;
    begin
      int n;
      busy_len(n);
      n_total++; if (n !== 0) $display("FAIL reset_idle_busy: got %0d want 0", n); else n_pass++;
    end
    capture(20);
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (seen[d] !== exp_seen(d, 0)) $display("FAIL reset_lit%0d: got %0b want %0b", d, seen[d], exp_seen(d, 0));
      else if (seen[d] && obs_seg[d] !== exp_digit(0, d % 2)) $display("FAIL reset_digit%0d: got %b want %b", d, obs_seg[d], exp_digit(0, d % 2));
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    int n;
    apply(1, 59);
    busy_len(n);
    n_total++; if (n !== 10) $display("FAIL basic_busy_len: got %0d want 10", n); else n_pass++;
    capture(20);
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (seen[d] !== exp_seen(d, 1)) $display("FAIL basic_lit%0d: got %0b want %0b", d, seen[d], exp_seen(d, 1));
      else if (seen[d] && obs_seg[d] !== exp_digit(d < 2 ? 59 : 1, d % 2)) $display("FAIL basic_digit%0d: got %b want %b", d, obs_seg[d], exp_digit(d < 2 ? 59 : 1, d % 2));
      else n_pass++;
    end
    n_total++; if (dp_err !== 0) $display("FAIL basic_dp: got %0d bad cycles want 0", dp_err); else n_pass++;
    n_total++; if (bus.ovr !== 1'b0) $display("FAIL basic_ovr: got %b want 0", bus.ovr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n;
    apply(12, 34);
    repeat (4) tick();
    n_total++; if (bus.busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", bus.busy); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.seg_n, bus.an_n, bus.dp_n, bus.busy, bus.ovr} !== {7'h7F, 4'hF, 1'b1, 1'b0, 1'b0})
      $display("FAIL midrst_outputs: got %h/%h/%b/%b/%b want 7f/f/1/0/0", bus.seg_n, bus.an_n, bus.dp_n, bus.busy, bus.ovr);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    busy_len(n);
    n_total++; if (n !== 10) $display("FAIL midrst_busy_len: got %0d want 10", n); else n_pass++;
    capture(20);
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (seen[d] !== exp_seen(d, 12)) $display("FAIL midrst_lit%0d: got %0b want %0b", d, seen[d], exp_seen(d, 12));
      else if (seen[d] && obs_seg[d] !== exp_digit(d < 2 ? 34 : 12, d % 2)) $display("FAIL midrst_digit%0d: got %b want %b", d, obs_seg[d], exp_digit(d < 2 ? 34 : 12, d % 2));
      else n_pass++;
    end
  endtask

  task automatic test_rollover();
    int n, rises, hi;
    bit prev;
    apply(3, 10);
    busy_len(n);
    n_total++; if (n !== 10) $display("FAIL roll_prep_busy: got %0d want 10", n); else n_pass++;
    apply(3, 58);
    rises = 0; hi = 0; prev = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.busy && !prev) rises++;
      if (bus.busy) hi++;
      prev = bus.busy;
      if (k == 0) apply(3, 59);
      if (k == 1) apply(3, 0);
    end
    n_total++; if (rises !== 2) $display("FAIL roll_conversions: got %0d want 2", rises); else n_pass++;
    n_total++; if (hi !== 20) $display("FAIL roll_busy_cycles: got %0d want 20", hi); else n_pass++;
    capture(20);
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (seen[d] !== exp_seen(d, 3)) $display("FAIL roll_lit%0d: got %0b want %0b", d, seen[d], exp_seen(d, 3));
      else if (seen[d] && obs_seg[d] !== exp_digit(d < 2 ? 0 : 3, d % 2)) $display("FAIL roll_digit%0d: got %b want %b", d, obs_seg[d], exp_digit(d < 2 ? 0 : 3, d % 2));
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    int n;
    int msbs [2] = '{150, 7};
    for (int s = 0; s < 2; s++) begin
      apply(msbs[s], 7);
      busy_len(n);
      n_total++; if (n !== 10) $display("FAIL ovr%0d_busy_len: got %0d want 10", s, n); else n_pass++;
      capture(20);
      for (int d = 0; d < 4; d++) begin
        n_total++;
        if (seen[d] !== exp_seen(d, msbs[s])) $display("FAIL ovr%0d_lit%0d: got %0b want %0b", s, d, seen[d], exp_seen(d, msbs[s]));
        else if (seen[d] && obs_seg[d] !== exp_digit(d < 2 ? 7 : msbs[s], d % 2)) $display("FAIL ovr%0d_digit%0d: got %b want %b", s, d, obs_seg[d], exp_digit(d < 2 ? 7 : msbs[s], d % 2));
        else n_pass++;
      end
      n_total++; if (bus.ovr !== (msbs[s] > 99)) $display("FAIL ovr%0d_flag: got %b want %b", s, bus.ovr, msbs[s] > 99); else n_pass++;
    end
  endtask

  task automatic test_disp_en();
    int bad, hi;
    bus.disp_en = 1'b0;
    apply(22, 45);
    bad = 0; hi = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.an_n !== 4'hF || bus.dp_n !== 1'b1) bad++;
      if (bus.busy) hi++;
    end
    n_total++; if (bad !== 0) $display("FAIL dispen_blank: got %0d lit cycles want 0", bad); else n_pass++;
    n_total++; if (hi !== 10) $display("FAIL dispen_busy: got %0d want 10", hi); else n_pass++;
    bus.disp_en = 1'b1;
    capture(20);
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (seen[d] !== exp_seen(d, 22)) $display("FAIL dispen_lit%0d: got %0b want %0b", d, seen[d], exp_seen(d, 22));
      else if (seen[d] && obs_seg[d] !== exp_digit(d < 2 ? 45 : 22, d % 2)) $display("FAIL dispen_digit%0d: got %b want %b", d, obs_seg[d], exp_digit(d < 2 ? 45 : 22, d % 2));
      else n_pass++;
    end
  endtask

  task automatic test_leading_zero();
    int n;
    int msbs [2] = '{5, 45};
    for (int s = 0; s < 2; s++) begin
      apply(msbs[s], 30);
      busy_len(n);
      capture(20);
      n_total++;
      if ((an3_low != 0) !== exp_seen(3, msbs[s])) $display("FAIL lz%0d_an3: got %0d low cycles want lit=%0b", s, an3_low, exp_seen(3, msbs[s]));
      else n_pass++;
      for (int d = 0; d < 4; d++) begin
        n_total++;
        if (seen[d] !== exp_seen(d, msbs[s])) $display("FAIL lz%0d_lit%0d: got %0b want %0b", s, d, seen[d], exp_seen(d, msbs[s]));
        else if (seen[d] && obs_seg[d] !== exp_digit(d < 2 ? 30 : msbs[s], d % 2)) $display("FAIL lz%0d_digit%0d: got %b want %b", s, d, obs_seg[d], exp_digit(d < 2 ? 30 : msbs[s], d % 2));
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int n, m, l, pm, pl;
    pm = int'(bus.msb_bin);
    pl = int'(bus.lsb_bin);
    for (int it = 0; it < 8; it++) begin
      do begin
        m = int'($urandom_range(130, 0));
        l = int'($urandom_range(130, 0));
      end while (m == pm && l == pl);
      pm = m; pl = l;
      apply(m, l);
      busy_len(n);
      n_total++; if (n !== 10) $display("FAIL rand%0d_busy_len: got %0d want 10", it, n); else n_pass++;
      capture(20);
      for (int d = 0; d < 4; d++) begin
        n_total++;
        if (seen[d] !== exp_seen(d, m)) $display("FAIL rand%0d_lit%0d: got %0b want %0b (m=%0d l=%0d)", it, d, seen[d], exp_seen(d, m), m, l);
        else if (seen[d] && obs_seg[d] !== exp_digit(d < 2 ? l : m, d % 2)) $display("FAIL rand%0d_digit%0d: got %b want %b (m=%0d l=%0d)", it, d, obs_seg[d], exp_digit(d < 2 ? l : m, d % 2), m, l);
        else n_pass++;
      end
      n_total++; if (dp_err !== 0) $display("FAIL rand%0d_dp: got %0d bad cycles want 0", it, dp_err); else n_pass++;
      n_total++; if (bus.ovr !== ((m > 99) || (l > 99))) $display("FAIL rand%0d_ovr: got %b want %b", it, bus.ovr, (m > 99) || (l > 99)); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_rollover();
    test_overflow();
    test_disp_en();
    test_leading_zero();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
